lcd_timing_gen: RTL and testbench

//  Parametrised raster timing generator and pixel output stage for LCD/VGA panels; successor to the fixed-timing LCD driver.

---
 rtl/lcd_timing_gen_pkg.sv | 27 ++
 rtl/lcd_timing_gen_if.sv | 32 +++
 rtl/lcd_timing_gen_pattern.sv | 59 +++++
 rtl/lcd_timing_gen.sv | 163 ++++++++++++++++
 tb/tb_lcd_timing_gen.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_timing_gen_pkg.sv
// lcd_timing_pkg: shared definitions for the LCD raster timing generator.
//   state_t      : sequencer states (IDLE / RUN / DRAIN)
//   PAT_*        : pattern_sel codes
//   DEF_*        : default 640x480@60 panel timing (clocks / lines)
package lcd_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] PAT_PASS  = 2'd0;
  localparam logic [1:0] PAT_BARS  = 2'd1;
  localparam logic [1:0] PAT_GRID  = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;

  localparam int DEF_H_SYNC  = 96;
  localparam int DEF_H_BACK  = 48;
  localparam int DEF_H_DISP  = 640;
  localparam int DEF_H_FRONT = 16;
  localparam int DEF_V_SYNC  = 2;
  localparam int DEF_V_BACK  = 33;
  localparam int DEF_V_DISP  = 480;
  localparam int DEF_V_FRONT = 10;

endpackage

// File: rtl/lcd_timing_gen_if.sv
// lcd_timing_gen_if: panel pins plus the pixel-fetch handshake.
//   master : the timing generator (drives panel pins, request/xpos/ypos,
//            frame/line pulses; receives lcd_data)
//   slave  : the frame-buffer reader / panel side
interface lcd_timing_gen_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 11
);
  logic              lcd_dclk;
  logic              lcd_hs;
  logic              lcd_vs;
  logic              lcd_de;
  logic [DATA_W-1:0] lcd_rgb;
  logic              lcd_request;
  logic [CNT_W-1:0]  lcd_xpos;
  logic [CNT_W-1:0]  lcd_ypos;
  logic              lcd_frame_start;
  logic              lcd_line_start;
  logic [DATA_W-1:0] lcd_data;

  modport master (
    output lcd_dclk, lcd_hs, lcd_vs, lcd_de, lcd_rgb,
    output lcd_request, lcd_xpos, lcd_ypos, lcd_frame_start, lcd_line_start,
    input  lcd_data
  );

  modport slave (
    input  lcd_dclk, lcd_hs, lcd_vs, lcd_de, lcd_rgb,
    input  lcd_request, lcd_xpos, lcd_ypos, lcd_frame_start, lcd_line_start,
    output lcd_data
  );
endinterface

// File: rtl/lcd_timing_gen_pattern.sv
// lcd_pattern_gen: combinational pixel source selection.
//   sel  : pattern code (pass-through / colour bars / grid / checker)
//   x, y : display-area coordinates of the pixel
//   data : user pixel, used only in pass-through
//   pix  : {R,G,B} pixel
module lcd_pattern_gen
  import lcd_timing_pkg::*;
#(
  parameter int R_W    = 5,
  parameter int G_W    = 6,
  parameter int B_W    = 5,
  parameter int H_DISP = 640,
  parameter int CNT_W  = 11,
  localparam int DATA_W = R_W + G_W + B_W
) (
  input  logic [1:0]        sel,
  input  logic [CNT_W-1:0]  x,
  input  logic [CNT_W-1:0]  y,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] pix
);
  localparam int COL_W = H_DISP / 8;

  logic [2:0] bar;
  logic       r_on, g_on, b_on;
  logic       unused_y;

  // checker/grid only look at the low five row bits
  assign unused_y = ^y[CNT_W-1:5];

  always_comb begin
    bar  = 3'(x / CNT_W'(COL_W));
    r_on = 1'b0;
    g_on = 1'b0;
    b_on = 1'b0;
    pix  = data;
    unique case (sel)
      // bar index bits map straight onto inverted channel enables:
      // white, yellow, cyan, green, magenta, red, blue, black
      PAT_BARS: begin
        r_on = ~bar[1];
        g_on = ~bar[2];
        b_on = ~bar[0];
      end
      PAT_GRID: begin
        r_on = (x[3:0] == 4'd0) || (y[3:0] == 4'd0);
        g_on = r_on;
        b_on = r_on;
      end
      PAT_CHECK: begin
        r_on = x[4] ^ y[4];
        g_on = r_on;
        b_on = r_on;
      end
      default: ;
    endcase
    if (sel != PAT_PASS) pix = {{R_W{r_on}}, {G_W{g_on}}, {B_W{b_on}}};
  end
endmodule

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: parametrised raster timing generator and pixel output stage.
//   clk, rst     : pixel clock, synchronous active-high reset
//   en           : run request; dropping it finishes the current frame first
//   pattern_sel  : pixel source, latched at frame start
//   busy         : sequencer not idle
//   bus          : panel pins + pixel-fetch handshake (master side)
// Request for pixel (x,y) in cycle t; lcd_data sampled REQ_LEAD cycles later;
// the registered panel pins for that pixel appear one cycle after that.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int H_DISP   = DEF_H_DISP,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int V_DISP   = DEF_V_DISP,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int R_W      = 5,
  parameter int G_W      = 6,
  parameter int B_W      = 5,
  parameter int CNT_W    = 11,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int REQ_LEAD = 1,
  localparam int DATA_W  = R_W + G_W + B_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        pattern_sel,
  output logic              busy,
  lcd_timing_gen_if.master  bus
);
  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int H_OFF   = H_SYNC + H_BACK;
  localparam int V_OFF   = V_SYNC + V_BACK;

  typedef struct packed {
    logic             hs;
    logic             vs;
    logic             act;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
  } tap_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  hcnt, vcnt;
  logic              h_last, v_last, run, act;
  logic [CNT_W-1:0]  x_raw, y_raw;
  tap_t              tap_in;
  tap_t              pipe [1:REQ_LEAD];
  logic [1:0]        pat_q;
  logic [DATA_W-1:0] pix;
  logic              hs_q, vs_q, de_q;
  logic [DATA_W-1:0] rgb_q;

  assign h_last = (hcnt == CNT_W'(H_TOTAL - 1));
  assign v_last = (vcnt == CNT_W'(V_TOTAL - 1));
  assign run    = (state != ST_IDLE);

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (en) state_nx = ST_RUN;
      ST_RUN:   if (!en) state_nx = ST_DRAIN;
      ST_DRAIN: begin
        if (en)                  state_nx = ST_RUN;
        else if (h_last && v_last) state_nx = ST_IDLE;
      end
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      hcnt  <= '0;
      vcnt  <= '0;
    end else begin
      state <= state_nx;
      // idle holds the raster at its origin so RUN starts from pixel (0,0)
      if (state == ST_IDLE) begin
        hcnt <= '0;
        vcnt <= '0;
      end else if (h_last) begin
        hcnt <= '0;
        vcnt <= v_last ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  // counter-domain view of the current position
  always_comb begin
    act = run
       && (hcnt >= CNT_W'(H_OFF)) && (hcnt < CNT_W'(H_OFF + H_DISP))
       && (vcnt >= CNT_W'(V_OFF)) && (vcnt < CNT_W'(V_OFF + V_DISP));
    x_raw      = act ? hcnt - CNT_W'(H_OFF) : '0;
    y_raw      = act ? vcnt - CNT_W'(V_OFF) : '0;
    tap_in.hs  = run && (hcnt < CNT_W'(H_SYNC));
    tap_in.vs  = run && (vcnt < CNT_W'(V_SYNC));
    tap_in.act = act;
    tap_in.x   = x_raw;
    tap_in.y   = y_raw;
  end

  assign busy                = run;
  assign bus.lcd_request     = act;
  assign bus.lcd_xpos        = x_raw;
  assign bus.lcd_ypos        = y_raw;
  assign bus.lcd_line_start  = run && (hcnt == '0);
  assign bus.lcd_frame_start = run && (hcnt == '0) && (vcnt == '0);
  assign bus.lcd_dclk        = ~clk;

  // delay line aligning sync/act/x/y with the returned lcd_data
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= REQ_LEAD; k++) pipe[k] <= '0;
    end else begin
      pipe[1] <= tap_in;
      for (int k = 2; k <= REQ_LEAD; k++) pipe[k] <= pipe[k-1];
    end
  end

  // pattern only switches on frame boundaries so a frame is never mixed
  always_ff @(posedge clk) begin
    if (rst)                      pat_q <= PAT_PASS;
    else if (bus.lcd_frame_start) pat_q <= pattern_sel;
  end

  lcd_pattern_gen #(
    .R_W(R_W), .G_W(G_W), .B_W(B_W), .H_DISP(H_DISP), .CNT_W(CNT_W)
  ) u_pat (
    .sel  (pat_q),
    .x    (pipe[REQ_LEAD].x),
    .y    (pipe[REQ_LEAD].y),
    .data (bus.lcd_data),
    .pix  (pix)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      de_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      hs_q  <= pipe[REQ_LEAD].hs ? HS_POL : ~HS_POL;
      vs_q  <= pipe[REQ_LEAD].vs ? VS_POL : ~VS_POL;
      de_q  <= pipe[REQ_LEAD].act;
      rgb_q <= pipe[REQ_LEAD].act ? pix : '0;
    end
  end

  assign bus.lcd_hs  = hs_q;
  assign bus.lcd_vs  = vs_q;
  assign bus.lcd_de  = de_q;
  assign bus.lcd_rgb = rgb_q;
endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: two small-raster instances (REQ_LEAD=1 active-low
// syncs, REQ_LEAD=3 active-high syncs) driven by shared stimulus and checked
// every cycle against a frame-position model, plus literal spot checks.
module tb_lcd_timing_gen;
  import lcd_timing_pkg::*;

  localparam int HS = 4, HB = 3, HD = 32, HF = 5;
  localparam int VS = 2, VB = 2, VD = 20, VF = 2;
  localparam int HT = HS + HB + HD + HF;   // 44
  localparam int VT = VS + VB + VD + VF;   // 26
  localparam int FRAME = HT * VT;          // 1144

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [15:0] data = 16'h0;
  logic        busy0, busy1;
  bit          chk_en = 1'b0;
  int          n_total = 0;
  int          n_bad = 0;

  lcd_timing_gen_if #(.DATA_W(16), .CNT_W(11)) if0 ();
  lcd_timing_gen_if #(.DATA_W(16), .CNT_W(11)) if1 ();
  assign if0.lcd_data = data;
  assign if1.lcd_data = data;

  lcd_timing_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
    .HS_POL(1'b0), .VS_POL(1'b0), .REQ_LEAD(1)
  ) u0 (.clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel), .busy(busy0), .bus(if0));

  lcd_timing_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
    .HS_POL(1'b1), .VS_POL(1'b1), .REQ_LEAD(3)
  ) u1 (.clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel), .busy(busy1), .bus(if1));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_total++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", nm, a, e, $time);
    end
  endtask

  function automatic logic [15:0] ref_pix(input logic [1:0] p, input int x, input int y,
                                          input logic [15:0] d);
    case (p)
      2'd0: return d;
      2'd1: case (x / (HD / 8))
              0: return 16'hFFFF;  1: return 16'hFFE0;
              2: return 16'h07FF;  3: return 16'h07E0;
              4: return 16'hF81F;  5: return 16'hF800;
              6: return 16'h001F;  default: return 16'h0000;
            endcase
      2'd2: return (x % 16 == 0 || y % 16 == 0) ? 16'hFFFF : 16'h0000;
      default: return (((x / 16) % 2) != ((y / 16) % 2)) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  // ---------------- reference model + per-cycle compare ----------------
  bit          m_on, m_drain;
  int          pos;
  logic [1:0]  m_pat;
  bit          h_act [8], h_hs [8], h_vs [8];
  int          h_x [8], h_y [8];
  logic [1:0]  h_pat [8];
  logic [15:0] h_dat [8];
  int          cyc;

  initial begin : model
    bit on, disp, pol, last;
    int hh, vv, ex, ey, lead, i, pi;
    logic [45:0] av, ev;
    m_on = 0; m_drain = 0; pos = 0; m_pat = 0; cyc = 8;
    for (int k = 0; k < 8; k++) begin
      h_act[k] = 0; h_hs[k] = 0; h_vs[k] = 0; h_x[k] = 0; h_y[k] = 0; h_pat[k] = 0; h_dat[k] = 0;
    end
    forever begin
      @(negedge clk); #1;
      if (chk_en) begin
        on   = m_on;
        hh   = pos % HT;
        vv   = pos / HT;
        disp = on && hh >= HS + HB && hh < HS + HB + HD && vv >= VS + VB && vv < VS + VB + VD;
        ex   = disp ? hh - (HS + HB) : 0;
        ey   = disp ? vv - (VS + VB) : 0;
        for (int k = 0; k < 2; k++) begin
          lead = (k == 0) ? 1 : 3;
          pol  = (k == 1);
          i    = (cyc - lead - 1) & 7;
          pi   = (cyc - 1) & 7;
          ev = {on, 1'b1, h_hs[i] ? pol : ~pol, h_vs[i] ? pol : ~pol, h_act[i], disp,
                on && pos == 0, on && hh == 0,
                h_act[i] ? ref_pix(h_pat[pi], h_x[i], h_y[i], h_dat[pi]) : 16'h0000,
                11'(ex), 11'(ey)};
          if (k == 0)
            av = {busy0, if0.lcd_dclk, if0.lcd_hs, if0.lcd_vs, if0.lcd_de, if0.lcd_request,
                  if0.lcd_frame_start, if0.lcd_line_start, if0.lcd_rgb, if0.lcd_xpos, if0.lcd_ypos};
          else
            av = {busy1, if1.lcd_dclk, if1.lcd_hs, if1.lcd_vs, if1.lcd_de, if1.lcd_request,
                  if1.lcd_frame_start, if1.lcd_line_start, if1.lcd_rgb, if1.lcd_xpos, if1.lcd_ypos};
          chk(k == 0 ? "u0 cycle outputs" : "u1 cycle outputs", 64'(av), 64'(ev));
        end
        h_act[cyc & 7] = disp;
        h_hs[cyc & 7]  = on && hh < HS;
        h_vs[cyc & 7]  = on && vv < VS;
        h_x[cyc & 7]   = ex;
        h_y[cyc & 7]   = ey;
        h_pat[cyc & 7] = m_pat;
        h_dat[cyc & 7] = data;
        if (rst) begin
          m_on = 0; m_drain = 0; pos = 0; m_pat = 0;
          for (int k = 0; k < 8; k++) begin h_act[k] = 0; h_hs[k] = 0; h_vs[k] = 0; end
        end else begin
          if (on && pos == 0) m_pat = pattern_sel;
          if (!on) begin
            if (en) m_on = 1;
          end else begin
            last = (pos == FRAME - 1);
            pos  = (pos + 1) % FRAME;
            if (m_drain) begin
              if (en) m_drain = 0;
              else if (last) begin m_on = 0; m_drain = 0; end
            end else if (!en) m_drain = 1;
          end
        end
        cyc++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
    data = 16'($urandom);
  endtask

  task automatic wait_px(input int x, input int y, input string nm);
    int n = 0;
    while (!(if0.lcd_request && int'(if0.lcd_xpos) == x && (y < 0 || int'(if0.lcd_ypos) == y))) begin
      if (n >= 3000) begin
        n_total++; n_bad++;
        $display("FAIL %s timeout got=none exp=request", nm);
        return;
      end
      step(); n++;
    end
  endtask

  task automatic wait_fs(input string nm);
    int n = 0;
    while (!if0.lcd_frame_start) begin
      if (n >= 3000) begin
        n_total++; n_bad++;
        $display("FAIL %s timeout got=none exp=frame_start", nm);
        return;
      end
      step(); n++;
    end
  endtask

  initial begin : stim
    int cnt, reqs, hsl, vsl, lss, noise;
    rst = 1'b1;
    step(); chk_en = 1'b1;
    step(); step();
    rst = 1'b0;

    // idle: nothing moves
    noise = 0;
    repeat (1000) begin
      step();
      noise += int'(if0.lcd_request) + int'(if0.lcd_frame_start) + int'(if0.lcd_line_start)
             + int'(if0.lcd_de) + int'(busy0);
    end
    chk("idle activity", 64'(noise), 64'd0);
    chk("idle busy", 64'(busy0), 64'd0);
    chk("idle hs pol0", 64'(if0.lcd_hs), 64'd1);
    chk("idle vs pol0", 64'(if0.lcd_vs), 64'd1);
    chk("idle hs pol1", 64'(if1.lcd_hs), 64'd0);
    chk("idle de", 64'(if0.lcd_de), 64'd0);
    chk("idle rgb", 64'(if0.lcd_rgb), 64'd0);

    // one full frame of raster counts
    en = 1'b1;
    step();
    wait_fs("first frame");
    cnt = 0; reqs = 0; hsl = 0; vsl = 0; lss = 0;
    do begin
      reqs += int'(if0.lcd_request);
      hsl  += int'(!if0.lcd_hs);
      vsl  += int'(!if0.lcd_vs);
      lss  += int'(if0.lcd_line_start);
      step(); cnt++;
    end while (!if0.lcd_frame_start && cnt < 5000);
    chk("frame period", 64'(cnt), 64'd1144);
    chk("requests per frame", 64'(reqs), 64'd640);
    chk("hs low clocks", 64'(hsl), 64'd104);
    chk("vs low clocks", 64'(vsl), 64'd88);
    chk("line starts", 64'(lss), 64'd26);

    // request-to-pixel latency for both lead settings
    wait_px(0, 0, "pixel 0,0");
    step(); data = 16'hABCD;
    step(); data = 16'hABCD;
    chk("lead1 rgb", 64'(if0.lcd_rgb), 64'hABCD);
    chk("lead1 de", 64'(if0.lcd_de), 64'd1);
    step(); data = 16'hABCD;
    step();
    chk("lead3 rgb", 64'(if1.lcd_rgb), 64'hABCD);

    // colour bars selected mid-frame, visible from the next frame
    pattern_sel = 2'd1;
    wait_fs("bars frame");
    wait_px(0, -1, "bars x0");  step(); step();
    chk("bars x=0", 64'(if0.lcd_rgb), 64'hFFFF);
    wait_px(4, -1, "bars x4");  step(); step();
    chk("bars x=4", 64'(if0.lcd_rgb), 64'hFFE0);
    wait_px(31, -1, "bars x31"); step(); step();
    chk("bars x=31", 64'(if0.lcd_rgb), 64'h0000);

    // drop and re-raise en inside the frame: no restart
    wait_px(0, 2, "drain start");
    en = 1'b0;
    repeat (50) step();
    en = 1'b1;
    chk("busy after re-raise", 64'(busy0), 64'd1);

    // drop en at line 10 (pos 447) and wait for the frame to finish
    wait_px(0, 6, "drain line");
    en = 1'b0;
    cnt = 0;
    while (busy0 && cnt < 2000) begin step(); cnt++; end
    chk("drain cycles", 64'(cnt), 64'd697);

    // reset in the middle of a display line
    en = 1'b1;
    wait_px(10, -1, "reset pixel");
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("reset de", 64'(if0.lcd_de), 64'd0);
    chk("reset rgb", 64'(if0.lcd_rgb), 64'd0);
    chk("reset busy", 64'(busy0), 64'd0);
    chk("reset hs pol1", 64'(if1.lcd_hs), 64'd0);

    // randomized run: en toggles, pattern switches, occasional resets
    for (int c = 0; c < 6000; c++) begin
      step();
      rst = 1'b0;
      if ($urandom_range(399) == 0) en = ~en;
      if ($urandom_range(149) == 0) pattern_sel = 2'($urandom);
      if ($urandom_range(1999) == 0) rst = 1'b1;
    end
    rst = 1'b0;
    step(); step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "bench timed out");
  end
endmodule
